// File: rtl/cycle_scheduler.sv
// Two-requester round-robin scheduler that runs a three-phase cycle (P0, P1, P2) followed by a
// one-cycle FIN. Phase lengths are latched at grant; all outputs are registered.
module cycle_scheduler #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] p0_len_i,
  input  logic [CNT_W-1:0] p1_len_i,
  input  logic [CNT_W-1:0] p2_len_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       phase_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_id_o,
  output logic             aborted_o
);

  typedef enum logic [2:0] {StIdle, StPh0, StPh1, StPh2, StFin} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len0_q, len1_q, len2_q;
  logic             owner_q;
  logic             last_q;

  logic [CNT_W-1:0] cur_len;
  logic [CNT_W:0]   cnt_inc;
  logic             phase_end;
  logic             grant_idx;

  always_comb begin
    cur_len = '0;
    case (state_q)
      StPh0:   cur_len = len0_q;
      StPh1:   cur_len = len1_q;
      StPh2:   cur_len = len2_q;
      default: cur_len = '0;
    endcase
  end

  // Extended by one bit so the compare cannot wrap; L=0 ends the phase after one cycle.
  assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign phase_end = cnt_inc >= {1'b0, cur_len};

  // Lone requester wins; on contention the one not served last wins.
  assign grant_idx = req_i[1] & (~req_i[0] | ~last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      len2_q    <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt_o     <= 2'b00;
      phase_o   <= 2'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      done_id_o <= 1'b0;
      aborted_o <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      aborted_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i != 2'b00 && !abort_i) begin
            state_q <= StPh0;
            cnt_q   <= '0;
            len0_q  <= p0_len_i;
            len1_q  <= p1_len_i;
            len2_q  <= p2_len_i;
            owner_q <= grant_idx;
            last_q  <= grant_idx;
            gnt_o   <= grant_idx ? 2'b10 : 2'b01;
            phase_o <= 2'd1;
            busy_o  <= 1'b1;
          end
        end
        StPh0, StPh1, StPh2: begin
          if (abort_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gnt_o     <= 2'b00;
            phase_o   <= 2'd0;
            busy_o    <= 1'b0;
            aborted_o <= 1'b1;
          end else if (phase_end) begin
            cnt_q <= '0;
            case (state_q)
              StPh0: begin
                state_q <= StPh1;
                phase_o <= 2'd2;
              end
              StPh1: begin
                state_q <= StPh2;
                phase_o <= 2'd3;
              end
              default: begin
                state_q   <= StFin;
                phase_o   <= 2'd0;
                done_o    <= 1'b1;
                done_id_o <= owner_q;
              end
            endcase
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        StFin: begin
          state_q <= StIdle;
          gnt_o   <= 2'b00;
          phase_o <= 2'd0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gnt_o   <= 2'b00;
          phase_o <= 2'd0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
